// File: rtl/sct_pkg.sv
// rtl/sct_pkg.sv - shared state encoding and direction constants for the sct sequencer
package sct_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sct_state_e;

  localparam logic SCT_DIR_UP = 1'b1;
  localparam logic SCT_DIR_DN = 1'b0;

endpackage

// File: rtl/sct_prescaler.sv
// rtl/sct_prescaler.sv - step prescaler: ticks once every psc+1 enabled cycles, clearable
module sct_prescaler #(
  parameter int PSC_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             cnt_en,
  input  logic [PSC_W-1:0] psc,
  output logic             tick
);

  logic [PSC_W-1:0] psc_cnt_q;
  logic [PSC_W-1:0] psc_cnt_d;

  // >= keeps the phase bounded if psc is lowered while the counter is above it
  assign tick = cnt_en && (psc_cnt_q >= psc);

  always_comb begin
    psc_cnt_d = psc_cnt_q;
    if (clr) begin
      psc_cnt_d = '0;
    end else if (cnt_en) begin
      psc_cnt_d = tick ? '0 : psc_cnt_q + {{(PSC_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc_cnt_q <= '0;
    end else begin
      psc_cnt_q <= psc_cnt_d;
    end
  end

endmodule

// File: rtl/sct_seq_counter.sv
// rtl/sct_seq_counter.sv - up/down sequencer counter with IDLE/RUN/DONE control
// Optional step prescaler and psc port enabled by defining SCT_PRESCALE_EN.
module sct_seq_counter
  import sct_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit WRAP_MODE = 1'b1,
  parameter int PSC_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] term_val,
  input  logic             dir,
  input  logic             start,
  input  logic             stop,
`ifdef SCT_PRESCALE_EN
  input  logic [PSC_W-1:0] psc,
`endif
  output logic [WIDTH-1:0] cnt,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  sct_state_e       state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tc_q, tc_d;
  logic [WIDTH-1:0] terminal;
  logic [WIDTH-1:0] wrap_val;
  logic [WIDTH-1:0] next_cnt;
  logic             step_tick;
  logic             step;

`ifdef SCT_PRESCALE_EN
  sct_prescaler #(.PSC_W(PSC_W)) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (load || stop || (state_q == IDLE && start)),
    .cnt_en (state_q == RUN && en),
    .psc    (psc),
    .tick   (step_tick)
  );
`else
  // Without the prescaler every enabled RUN cycle is a step.
  assign step_tick = (PSC_W > 0);
`endif

  assign terminal = (dir == SCT_DIR_UP) ? term_val : '0;
  assign wrap_val = (dir == SCT_DIR_DN) ? term_val : '0;
  assign next_cnt = (dir == SCT_DIR_UP) ? cnt_q + {{(WIDTH-1){1'b0}}, 1'b1}
                                        : cnt_q - {{(WIDTH-1){1'b0}}, 1'b1};
  assign step     = (state_q == RUN) && en && step_tick && !load && !stop;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tc_d    = 1'b0;

    if (load) begin
      cnt_d = load_val;
    end else if (step) begin
      if (WRAP_MODE && cnt_q == terminal) begin
        cnt_d = wrap_val;
      end else begin
        cnt_d = next_cnt;
        tc_d  = (next_cnt == terminal);
        if (tc_d && !WRAP_MODE) begin
          state_d = DONE;
        end
      end
    end

    // stop outranks start; a load out of DONE rearms to IDLE
    if (stop) begin
      state_d = IDLE;
    end else if (start && state_q == IDLE) begin
      state_d = RUN;
    end else if (load && state_q == DONE) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tc_q    <= tc_d;
    end
  end

  assign cnt  = cnt_q;
  assign tc   = tc_q;
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_sct_seq_counter.sv
// tb/tb_sct_seq_counter.sv - directed self-checking bench for sct_seq_counter (one-shot and wrap instances)
module tb_sct_seq_counter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_val = 8'h00;
  logic [7:0] term_val = 8'h00;
  logic       dir = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
`ifdef SCT_PRESCALE_EN
  logic [3:0] psc = 4'd0;
`endif

  logic [7:0] cnt0, cnt1;
  logic       tc0, tc1, busy0, busy1, done0, done1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sct_seq_counter #(.WIDTH(8), .WRAP_MODE(1'b0), .PSC_W(4)) u_oneshot (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .load_val(load_val),
    .term_val(term_val), .dir(dir), .start(start), .stop(stop),
`ifdef SCT_PRESCALE_EN
    .psc(psc),
`endif
    .cnt(cnt0), .tc(tc0), .busy(busy0), .done(done0)
  );

  sct_seq_counter #(.WIDTH(8), .WRAP_MODE(1'b1), .PSC_W(4)) u_wrap (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .load_val(load_val),
    .term_val(term_val), .dir(dir), .start(start), .stop(stop),
`ifdef SCT_PRESCALE_EN
    .psc(psc),
`endif
    .cnt(cnt1), .tc(tc1), .busy(busy1), .done(done1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic load_start(input logic [7:0] v);
    stop = 1'b1;
    edge1();
    stop = 1'b0;
    load = 1'b1;
    start = 1'b1;
    load_val = v;
    edge1();
    load = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    // reset values
    edge1();
    chk("rst_cnt", cnt1, 8'h00);
    chk("rst_tc", tc1, 1'b0);
    chk("rst_busy", busy1, 1'b0);
    chk("rst_done", done1, 1'b0);
    rst_n = 1'b1;
    edge1();

    // one-shot up to FF
    en = 1'b1; dir = 1'b1; term_val = 8'hFF;
    load = 1'b1; start = 1'b1; load_val = 8'hFD;
    edge1();
    load = 1'b0; start = 1'b0;
    chk("os_load_cnt", cnt0, 8'hFD);
    chk("os_busy", busy0, 1'b1);
    edge1();
    chk("os_fe", cnt0, 8'hFE);
    chk("os_fe_tc", tc0, 1'b0);
    edge1();
    chk("os_ff", cnt0, 8'hFF);
    chk("os_ff_tc", tc0, 1'b1);
    chk("os_done", done0, 1'b1);
    chk("os_nbusy", busy0, 1'b0);
    chk("wr_ff_tc", tc1, 1'b1);
    edge1();
    chk("os_hold", cnt0, 8'hFF);
    chk("os_tc_pulse", tc0, 1'b0);
    chk("os_done_hold", done0, 1'b1);
    chk("wr_wrap_up", cnt1, 8'h00);

    // wrap down 2 -> 1,0,5,4
    dir = 1'b0; term_val = 8'h05;
    load_start(8'h02);
    chk("dn_load", cnt1, 8'h02);
    edge1();
    chk("dn_1", cnt1, 8'h01);
    chk("dn_1_tc", tc1, 1'b0);
    edge1();
    chk("dn_0", cnt1, 8'h00);
    chk("dn_0_tc", tc1, 1'b1);
    edge1();
    chk("dn_5", cnt1, 8'h05);
    chk("dn_5_tc", tc1, 1'b0);
    chk("dn_busy", busy1, 1'b1);
    edge1();
    chk("dn_4", cnt1, 8'h04);

    // stop beats start, resume without step on entry
    dir = 1'b1; term_val = 8'hFF;
    en = 1'b0;
    load_start(8'h10);
    en = 1'b1;
    stop = 1'b1; start = 1'b1;
    edge1();
    stop = 1'b0; start = 1'b0;
    chk("stop_cnt", cnt1, 8'h10);
    chk("stop_busy", busy1, 1'b0);
    start = 1'b1;
    edge1();
    start = 1'b0;
    chk("resume_cnt", cnt1, 8'h10);
    chk("resume_busy", busy1, 1'b1);
    edge1();
    chk("resume_step", cnt1, 8'h11);

    // enable gating 1,0,0,1 from 0x20
    en = 1'b0;
    load_start(8'h20);
    en = 1'b1;
    edge1();
    chk("en_a", cnt1, 8'h21);
    en = 1'b0;
    edge1();
    chk("en_b", cnt1, 8'h21);
    edge1();
    chk("en_c", cnt1, 8'h21);
    en = 1'b1;
    edge1();
    chk("en_d", cnt1, 8'h22);
    chk("en_tc", tc1, 1'b0);

    // async reset mid-run at 0x37
    en = 1'b0;
    load_start(8'h37);
    chk("pre_rst", cnt1, 8'h37);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_cnt", cnt1, 8'h00);
    chk("arst_tc", tc1, 1'b0);
    chk("arst_busy", busy1, 1'b0);
    chk("arst_done", done0, 1'b0);
    edge1();
    rst_n = 1'b1;

`ifdef SCT_PRESCALE_EN
    // psc=2: one step per 3 enabled cycles; load restarts the phase
    psc = 4'd2; en = 1'b1; dir = 1'b1; term_val = 8'hFF;
    load_start(8'h00);
    edge1(); chk("psc_1", cnt1, 8'h00);
    edge1(); chk("psc_2", cnt1, 8'h00);
    edge1(); chk("psc_3", cnt1, 8'h01);
    edge1(); edge1();
    edge1(); chk("psc_6", cnt1, 8'h02);
    edge1();
    load = 1'b1; load_val = 8'h50;
    edge1();
    load = 1'b0;
    chk("psc_ld", cnt1, 8'h50);
    edge1(); chk("psc_ld1", cnt1, 8'h50);
    edge1(); chk("psc_ld2", cnt1, 8'h50);
    edge1(); chk("psc_ld3", cnt1, 8'h51);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
